interval_dispatcher: RTL

Schedules interval records (start index, end index, id) from the head of the interval queue onto a pool of prediction workers. It pops one record at a time and checks that it is well-formed. It then hands the record to a free worker in round-robin order and tracks per-worker busy state until that worker signals completion. It sits between the interval queue and the worker array, and is the only agent that pops the queue.

---
 rtl/interval_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 42 ++++
 rtl/interval_dispatcher.sv | 139 +++++++++++++
 3 files changed

// File: rtl/interval_pkg.sv
// Shared types and constants for the interval scheduling blocks.
//   state_e     : dispatcher FSM states
//   DW_DEFAULT  : default width of the si/ei/id record fields
//   MAX_WORKERS : largest supported worker pool
//   WIDX_W      : width of a worker index, sized for MAX_WORKERS
package interval_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ARB,
    S_ISSUE
  } state_e;

  localparam int DW_DEFAULT  = 32;
  localparam int MAX_WORKERS = 16;
  localparam int WIDX_W      = $clog2(MAX_WORKERS);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   in  N       request vector
//   ptr   in  WIDX_W  highest-priority index (must be < N)
//   found out 1       at least one request is set
//   idx   out WIDX_W  first requester at or above ptr, wrapping
module rr_arbiter
  import interval_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]      req,
  input  logic [WIDX_W-1:0] ptr,
  output logic              found,
  output logic [WIDX_W-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] shifted;
  logic [N-1:0]   rot;

  // Rotate so that bit 0 of rot corresponds to req[ptr].
  assign dbl     = {req, req};
  assign shifted = dbl >> ptr;
  assign rot     = shifted[N-1:0];

  always_comb begin
    int sum;
    sum   = 0;
    found = 1'b0;
    idx   = '0;
    // Descending scan so the lowest rotated offset wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        sum   = int'(ptr) + k;
        if (sum >= N) sum = sum - N;
        idx   = WIDX_W'(sum);
      end
    end
  end

endmodule

// File: rtl/interval_dispatcher.sv
// Pops interval records from the queue head, rejects malformed ones
// (ei < si) and issues the rest round-robin to free workers.
//   clk, rst             clock, synchronous active-high reset
//   enable               permits starting a new pop
//   q_empty, q_si/ei/id  head-of-queue record
//   q_pop                pulse, advances queue head
//   wk_ready, wk_done    per-worker ready level / completion pulse
//   wk_valid, wk_si/ei/id one-hot issue strobe and record bus
//   busy                 per-worker outstanding record
//   err_len              pulse, malformed record dropped
//   issued_cnt           records issued since reset (wraps)
//   idle                 nothing in flight, nothing queued
module interval_dispatcher
  import interval_pkg::*;
#(
  parameter int NUM_WORKERS = 4,
  parameter int DW          = DW_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   q_empty,
  input  logic [DW-1:0]          q_si,
  input  logic [DW-1:0]          q_ei,
  input  logic [DW-1:0]          q_id,
  output logic                   q_pop,
  input  logic [NUM_WORKERS-1:0] wk_ready,
  input  logic [NUM_WORKERS-1:0] wk_done,
  output logic [NUM_WORKERS-1:0] wk_valid,
  output logic [DW-1:0]          wk_si,
  output logic [DW-1:0]          wk_ei,
  output logic [DW-1:0]          wk_id,
  output logic [NUM_WORKERS-1:0] busy,
  output logic                   err_len,
  output logic [DW-1:0]          issued_cnt,
  output logic                   idle
);

  state_e                 state_q, state_d;
  logic [DW-1:0]          rec_si_q, rec_si_d;
  logic [DW-1:0]          rec_ei_q, rec_ei_d;
  logic [DW-1:0]          rec_id_q, rec_id_d;
  logic [WIDX_W-1:0]      g_q, g_d;
  logic [WIDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_WORKERS-1:0] busy_q, busy_d;
  logic [DW-1:0]          cnt_q, cnt_d;

  logic [NUM_WORKERS-1:0] free;
  logic [NUM_WORKERS-1:0] g_oh;
  logic                   arb_found;
  logic [WIDX_W-1:0]      arb_idx;
  logic                   bad_len;

  assign free    = wk_ready & ~busy_q;
  assign bad_len = rec_ei_q < rec_si_q;

  rr_arbiter #(.N(NUM_WORKERS)) u_arb (
    .req   (free),
    .ptr   (rr_ptr_q),
    .found (arb_found),
    .idx   (arb_idx)
  );

  always_comb begin
    g_oh = '0;
    for (int i = 0; i < NUM_WORKERS; i++) g_oh[i] = (g_q == WIDX_W'(i));
  end

  always_comb begin
    state_d  = state_q;
    rec_si_d = rec_si_q;
    rec_ei_d = rec_ei_q;
    rec_id_d = rec_id_q;
    g_d      = g_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    // Completions always land; a done from an idle worker is a no-op.
    busy_d   = busy_q & ~wk_done;
    case (state_q)
      S_IDLE: if (enable && !q_empty) state_d = S_FETCH;
      S_FETCH: begin
        rec_si_d = q_si;
        rec_ei_d = q_ei;
        rec_id_d = q_id;
        state_d  = S_ARB;
      end
      S_ARB: begin
        if (bad_len) begin
          state_d = S_IDLE;
        end else if (arb_found) begin
          g_d     = arb_idx;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // g was picked from ~busy, so it cannot collide with a done.
        busy_d   = busy_d | g_oh;
        rr_ptr_d = (g_q == WIDX_W'(NUM_WORKERS - 1)) ? '0 : g_q + WIDX_W'(1);
        cnt_d    = cnt_q + DW'(1);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rec_si_q <= '0;
      rec_ei_q <= '0;
      rec_id_q <= '0;
      g_q      <= '0;
      rr_ptr_q <= '0;
      busy_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rec_si_q <= rec_si_d;
      rec_ei_q <= rec_ei_d;
      rec_id_q <= rec_id_d;
      g_q      <= g_d;
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs decode registered state only.
  assign q_pop      = (state_q == S_FETCH);
  assign wk_valid   = (state_q == S_ISSUE) ? g_oh : '0;
  assign wk_si      = rec_si_q;
  assign wk_ei      = rec_ei_q;
  assign wk_id      = rec_id_q;
  assign busy       = busy_q;
  assign err_len    = (state_q == S_ARB) && bad_len;
  assign issued_cnt = cnt_q;
  assign idle       = (state_q == S_IDLE) && (busy_q == '0) && q_empty;

endmodule
